// File: rtl/apb_master.sv
// APB initiator: address-slot decode, SETUP/ACCESS sequencing, registered response.
// Optional ACCESS-phase timeout is compiled in with `define APB_TIMEOUT_EN.
module apb_master #(
    parameter int          NUM_SLAVES     = 4,
    parameter logic [31:0] BASE_ADDR      = 32'h1000_0000,
    parameter int          SLOT_BITS      = 12,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic                     transfer,
    input  logic                     write,
    input  logic [31:0]              addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata,
    output logic                     ready,
    output logic                     error,
    output logic                     busy,
    output logic [31:0]              PADDR,
    output logic                     PWRITE,
    output logic [31:0]              PWDATA,
    output logic                     PENABLE,
    output logic [NUM_SLAVES-1:0]    PSEL,
    input  logic [32*NUM_SLAVES-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]    PREADY
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    if (NUM_SLAVES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("apb_master: NUM_SLAVES and TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state_q, state_d;
    logic [31:0]           paddr_q, paddr_d;
    logic                  pwrite_q, pwrite_d;
    logic [31:0]           pwdata_q, pwdata_d;
    logic                  penable_q, penable_d;
    logic [NUM_SLAVES-1:0] psel_q, psel_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  ready_q, ready_d;
    logic                  error_q, error_d;
    logic                  busy_q, busy_d;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Offset is 32-bit unsigned; the >= guard keeps low addresses from wrapping into a slot
    logic [31:0] offset;
    logic [31:0] slot;
    logic        hit;

    assign offset = addr - BASE_ADDR;
    assign slot   = offset >> SLOT_BITS;
    assign hit    = (addr >= BASE_ADDR) && (slot < 32'(NUM_SLAVES));

    logic [31:0] prdata_sel;
    logic        pready_sel;

    always_comb begin
        prdata_sel = '0;
        pready_sel = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                prdata_sel = PRDATA[32*i +: 32];
                pready_sel = PREADY[i];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        paddr_d   = paddr_q;
        pwrite_d  = pwrite_q;
        pwdata_d  = pwdata_q;
        penable_d = penable_q;
        psel_d    = psel_q;
        idx_d     = idx_q;
        rdata_d   = '0;
        ready_d   = 1'b0;
        error_d   = 1'b0;
        busy_d    = busy_q;
`ifdef APB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                psel_d    = '0;
                penable_d = 1'b0;
                busy_d    = 1'b0;
                if (transfer) begin
                    busy_d = 1'b1;
                    if (hit) begin
                        state_d  = SETUP;
                        paddr_d  = addr;
                        pwrite_d = write;
                        pwdata_d = wdata;
                        idx_d    = slot[IDX_W-1:0];
                        psel_d   = NUM_SLAVES'(1) << slot[IDX_W-1:0];
                    end else begin
                        state_d = RESP;
                        ready_d = 1'b1;
                        error_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
`ifdef APB_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ACCESS: begin
                if (pready_sel) begin
                    state_d   = RESP;
                    ready_d   = 1'b1;
                    rdata_d   = pwrite_q ? 32'h0 : prdata_sel;
                    psel_d    = '0;
                    penable_d = 1'b0;
                end
`ifdef APB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = RESP;
                    ready_d   = 1'b1;
                    error_d   = 1'b1;
                    psel_d    = '0;
                    penable_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            RESP: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q   <= IDLE;
            paddr_q   <= '0;
            pwrite_q  <= 1'b0;
            pwdata_q  <= '0;
            penable_q <= 1'b0;
            psel_q    <= '0;
            idx_q     <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef APB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            paddr_q   <= paddr_d;
            pwrite_q  <= pwrite_d;
            pwdata_q  <= pwdata_d;
            penable_q <= penable_d;
            psel_q    <= psel_d;
            idx_q     <= idx_d;
            rdata_q   <= rdata_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
            busy_q    <= busy_d;
`ifdef APB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    assign PADDR   = paddr_q;
    assign PWRITE  = pwrite_q;
    assign PWDATA  = pwdata_q;
    assign PENABLE = penable_q;
    assign PSEL    = psel_q;
    assign rdata   = rdata_q;
    assign ready   = ready_q;
    assign error   = error_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_apb_master.sv
// Scoreboard bench for apb_master: directed requests, behavioural slaves,
// decoupled response monitor and per-cycle APB phase checks.
module tb_apb_master;

    logic         PCLK;
    logic         PRESET;
    logic         transfer;
    logic         write;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         ready;
    logic         error;
    logic         busy;
    logic [31:0]  PADDR;
    logic         PWRITE;
    logic [31:0]  PWDATA;
    logic         PENABLE;
    logic [3:0]   PSEL;
    logic [127:0] PRDATA;
    logic [3:0]   PREADY;

    apb_master dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .transfer(transfer),
        .write   (write),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .ready   (ready),
        .error   (error),
        .busy    (busy),
        .PADDR   (PADDR),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PENABLE (PENABLE),
        .PSEL    (PSEL),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge PCLK) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    logic [3:0]  exp_psel  = '0;
    logic [31:0] exp_addr  = '0;
    logic        exp_wr    = 1'b0;
    logic [31:0] exp_wdata = '0;
    int          exp_waits = 0;
    logic        force3    = 1'b0;

    // Response monitor
    always @(negedge PCLK) begin
        if (PRESET && ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: ready at cyc %0d with nothing pending", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (rdata !== e.rdata || error !== e.err || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL resp: got rdata=%h err=%b cyc=%0d, want rdata=%h err=%b cyc=%0d",
                             rdata, error, cyc, e.rdata, e.err, e.cyc);
                end
            end
        end
    end

    // Slave model plus APB phase checker
    int phase = 0;
    int wcnt  = 0;
    always @(negedge PCLK) begin
        logic [3:0] prv;
        prv = force3 ? 4'b1000 : 4'b0000;
        if (PSEL != 4'b0) begin
            checks++;
            if (PSEL !== exp_psel || PADDR !== exp_addr || PWRITE !== exp_wr ||
                PWDATA !== exp_wdata || PENABLE !== (phase != 0)) begin
                errors++;
                $display("FAIL apb_phase %0d: got sel=%b a=%h w=%b wd=%h en=%b, want sel=%b a=%h w=%b wd=%h en=%b",
                         phase, PSEL, PADDR, PWRITE, PWDATA, PENABLE,
                         exp_psel, exp_addr, exp_wr, exp_wdata, phase != 0);
            end
            phase++;
        end else begin
            phase = 0;
        end
        if (PSEL != 4'b0 && PENABLE) begin
            if (wcnt >= exp_waits) prv = prv | PSEL;
            else wcnt++;
        end else begin
            wcnt = 0;
        end
        PREADY = prv;
    end

    task automatic wait_idle(input string name);
        for (int i = 0; i < 60; i++) begin
            if (!busy) return;
            @(negedge PCLK);
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: busy=%b after 60 cycles, want 0", name, busy);
    endtask

    task automatic start(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                         input logic [3:0] sel, input int waits, input int lat,
                         input logic [31:0] rd, input logic err);
        @(negedge PCLK);
        exp_psel  = sel;
        exp_addr  = a;
        exp_wr    = wr;
        exp_wdata = wd;
        exp_waits = waits;
        exp_q.push_back('{cyc: cyc + lat, rdata: rd, err: err});
        transfer = 1'b1;
        write    = wr;
        addr     = a;
        wdata    = wd;
    endtask

    task automatic req(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] sel, input int waits, input int lat,
                       input logic [31:0] rd, input logic err);
        start(wr, a, wd, sel, waits, lat, rd, err);
        @(negedge PCLK);
        transfer = 1'b0;
        write    = ~wr;
        addr     = 32'hDEAD_BEEF;
        wdata    = ~wd;
        wait_idle("req");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        PRESET   = 1'b0;
        transfer = 1'b0;
        write    = 1'b0;
        addr     = '0;
        wdata    = '0;
        PREADY   = '0;
        PRDATA   = {32'h3333_3333, 32'h0000_1234, 32'h1111_1111, 32'hCAFE_0000};
        repeat (3) @(negedge PCLK);
        checks++;
        if ({rdata, ready, error, busy, PADDR, PWRITE, PWDATA, PENABLE, PSEL} !== '0) begin
            errors++;
            $display("FAIL reset_state: got sel=%b en=%b busy=%b ready=%b, want all zero",
                     PSEL, PENABLE, busy, ready);
        end
        PRESET = 1'b1;
        @(negedge PCLK);

        req(1'b1, 32'h1000_1004, 32'hA5A5_0001, 4'b0010, 0, 3, 32'h0, 1'b0);
        req(1'b0, 32'h1000_200C, 32'h0,         4'b0100, 3, 6, 32'h0000_1234, 1'b0);
        req(1'b0, 32'h0FFF_FFFC, 32'h0,         4'b0000, 0, 1, 32'h0, 1'b1);
        req(1'b1, 32'h1000_4000, 32'h1234_5678, 4'b0000, 0, 1, 32'h0, 1'b1);
        req(1'b0, 32'h1000_3FFC, 32'h0,         4'b1000, 1, 4, 32'h3333_3333, 1'b0);
        req(1'b0, 32'h1000_0000, 32'h0,         4'b0001, 0, 3, 32'hCAFE_0000, 1'b0);
        req(1'b1, 32'h1000_2000, 32'h0BAD_F00D, 4'b0100, 2, 5, 32'h0, 1'b0);
        req(1'b0, 32'hFFFF_F000, 32'h0,         4'b0000, 0, 1, 32'h0, 1'b1);

        // Transfer held through busy and RESP, stray PREADY[3]: only one completion
        force3 = 1'b1;
        start(1'b1, 32'h1000_1008, 32'h5555_AAAA, 4'b0010, 2, 5, 32'h0, 1'b0);
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 20 && !seen; i++) begin
                @(negedge PCLK);
                addr  = 32'h1000_0010;
                write = 1'b0;
                seen  = ready;
            end
            if (!seen) begin
                checks++;
                errors++;
                $display("FAIL busy_hold_timeout: ready=%b after 20 cycles, want 1", ready);
            end
        end
        @(negedge PCLK);
        transfer = 1'b0;
        checks++;
        if (busy !== 1'b0 || PSEL !== 4'b0) begin
            errors++;
            $display("FAIL busy_ignore: got busy=%b sel=%b, want busy=0 sel=0000", busy, PSEL);
        end
        repeat (3) @(negedge PCLK);
        force3 = 1'b0;

        // Asynchronous reset in ACCESS
        start(1'b0, 32'h1000_0040, 32'h0, 4'b0001, 20, 23, 32'hCAFE_0000, 1'b0);
        @(negedge PCLK);
        transfer = 1'b0;
        for (int i = 0; i < 10 && !PENABLE; i++) @(negedge PCLK);
        @(negedge PCLK);
        #2 PRESET = 1'b0;
        #1;
        checks++;
        if ({PSEL, PENABLE, busy, ready} !== 7'b0) begin
            errors++;
            $display("FAIL async_reset: got sel=%b en=%b busy=%b ready=%b, want all 0",
                     PSEL, PENABLE, busy, ready);
        end
        void'(exp_q.pop_back());
        repeat (2) @(negedge PCLK);
        PRESET = 1'b1;
        repeat (2) @(negedge PCLK);
        req(1'b0, 32'h1000_1010, 32'h0, 4'b0010, 1, 4, 32'h1111_1111, 1'b0);

`ifdef APB_TIMEOUT_EN
        req(1'b0, 32'h1000_2010, 32'h0, 4'b0100, 100, 18, 32'h0, 1'b1);
        req(1'b0, 32'h1000_2014, 32'h0, 4'b0100, 15,  18, 32'h0000_1234, 1'b0);
`endif

        repeat (4) @(negedge PCLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending: got %0d outstanding responses, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
